// File: rtl/line_fill_arbiter_if.sv
// Bundle of the two cache-controller line request ports and the unified
// memory data port. The arbiter connects through the slave modport.
interface line_fill_arbiter_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
);
  // I-cache refill port
  logic                            i_req;
  logic [WORD_SIZE-1:0]            i_addr;
  logic [WORD_SIZE*LINE_WORDS-1:0] i_rline;
  logic                            i_done;
  // D-cache refill / write-back port
  logic                            d_req;
  logic                            d_we;
  logic [WORD_SIZE-1:0]            d_addr;
  logic [WORD_SIZE*LINE_WORDS-1:0] d_wline;
  logic [WORD_SIZE*LINE_WORDS-1:0] d_rline;
  logic                            d_done;
  // Memory data port
  logic                            mem_read;
  logic                            mem_write;
  logic [WORD_SIZE-1:0]            mem_addr;
  logic [WORD_SIZE-1:0]            mem_wdata;
  logic [WORD_SIZE-1:0]            mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wline, mem_rdata,
    output i_rline, i_done, d_rline, d_done,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wline, mem_rdata,
    input  i_rline, i_done, d_rline, d_done,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/line_fill_arbiter.sv
// Round-robin arbiter that moves whole cache lines between the I/D cache
// controllers and the single-port unified memory, one word transaction at a
// time, paced to the memory's fixed read latency.
module line_fill_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  line_fill_arbiter_if.slave bus
);

  localparam int OFF    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  localparam logic [WORD_SIZE-1:0] LINE_MASK = WORD_SIZE'(LINE_WORDS - 1);
  localparam logic [OFF-1:0]       LAST_IDX  = OFF'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]     WAIT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Grant and line bookkeeping; r_grant_d/r_last_d: 1 = D side, 0 = I side
  logic                 r_grant_d;
  logic                 r_last_d;
  logic                 r_we;
  logic [WORD_SIZE-1:0] r_base;
  logic [OFF-1:0]       r_word_idx;
  logic [CNT_W-1:0]     r_wait_cnt;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic [LINE_W-1:0]    r_i_rline;
  logic [LINE_W-1:0]    r_d_rline;

  logic                 w_req_any;
  logic                 w_pick_d;
  logic [WORD_SIZE-1:0] w_base_in;
  logic [OFF-1:0]       w_word_nxt;
  logic [WORD_SIZE-1:0] w_next_addr;
  logic                 w_wait_last;
  logic                 w_line_last;
  logic [WORD_SIZE-1:0] w_wdata_nxt;
  logic                 w_mem_read;
  logic                 w_mem_write;
  logic                 w_i_done;
  logic                 w_d_done;

  // On a tie the side that did not win last time gets the line.
  assign w_req_any   = bus.i_req | bus.d_req;
  assign w_pick_d    = bus.d_req & (~bus.i_req | ~r_last_d);
  assign w_base_in   = (w_pick_d ? bus.d_addr : bus.i_addr) & ~LINE_MASK;
  assign w_word_nxt  = r_word_idx + OFF'(1);
  assign w_next_addr = r_base | {{(WORD_SIZE-OFF){1'b0}}, w_word_nxt};
  assign w_wait_last = (r_wait_cnt == '0);
  assign w_line_last = (r_word_idx == LAST_IDX);

  // Select the write-back word that the next ISSUE cycle will drive.
  always_comb begin
    w_wdata_nxt = bus.d_wline[WORD_SIZE-1:0];
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (w_word_nxt == OFF'(k)) w_wdata_nxt = bus.d_wline[k*WORD_SIZE +: WORD_SIZE];
    end
  end

  // State register; reset aborts any line in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and the single-cycle strobe / done outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_i_done    = 1'b0;
    w_d_done    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req_any) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_mem_write = r_we;
        w_mem_read  = ~r_we;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_last) w_state_nxt = w_line_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_i_done    = ~r_grant_d;
        w_d_done    = r_grant_d;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant latch, word sequencing, memory address/data and line capture.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_grant_d   <= 1'b0;
      r_last_d    <= 1'b0;
      r_we        <= 1'b0;
      r_base      <= '0;
      r_word_idx  <= '0;
      r_wait_cnt  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rline   <= '0;
      r_d_rline   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_grant_d  <= w_pick_d;
            r_we       <= w_pick_d & bus.d_we;
            r_base     <= w_base_in;
            r_word_idx <= '0;
            r_mem_addr <= w_base_in;
            if (w_pick_d & bus.d_we) r_mem_wdata <= bus.d_wline[WORD_SIZE-1:0];
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= WAIT_INIT;
        end
        S_WAIT: begin
          if (!w_wait_last) begin
            r_wait_cnt <= r_wait_cnt - CNT_W'(1);
          end else begin
            if (!r_we) begin
              for (int k = 0; k < LINE_WORDS; k++) begin
                if (r_word_idx == OFF'(k)) begin
                  if (r_grant_d) r_d_rline[k*WORD_SIZE +: WORD_SIZE] <= bus.mem_rdata;
                  else           r_i_rline[k*WORD_SIZE +: WORD_SIZE] <= bus.mem_rdata;
                end
              end
            end
            // The index stays put after the last word; IDLE reloads it.
            if (!w_line_last) begin
              r_word_idx <= w_word_nxt;
              r_mem_addr <= w_next_addr;
              if (r_we) r_mem_wdata <= w_wdata_nxt;
            end
          end
        end
        S_DONE: begin
          r_last_d <= r_grant_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_rline   = r_i_rline;
  assign bus.d_rline   = r_d_rline;
  assign bus.i_done    = w_i_done;
  assign bus.d_done    = w_d_done;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Bench for line_fill_arbiter: a timed 256x16 memory model, directed scenarios
// and a randomized run against a transaction-level reference model.
module tb_line_fill_arbiter;

  localparam int WORD_SIZE  = 16;
  localparam int LINE_WORDS = 4;
  localparam int MEM_LAT    = 2;
  localparam int LINE_W     = WORD_SIZE * LINE_WORDS;
  localparam int STEP       = MEM_LAT + 1;
  localparam int XFER       = 1 + LINE_WORDS * STEP;

  typedef struct {
    int          cyc;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } strobe_t;

  typedef struct {
    int                cyc;
    logic              d;
    logic [LINE_W-1:0] il;
    logic [LINE_W-1:0] dl;
  } done_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  line_fill_arbiter_if #(.WORD_SIZE(WORD_SIZE), .LINE_WORDS(LINE_WORDS)) bus ();

  line_fill_arbiter #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .MEM_LAT   (MEM_LAT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  strobe_t     obs_s[$];
  done_t       obs_d[$];
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  int          cyc;
  int          checks;
  int          errors;
  int          rd_cyc;
  logic [7:0]  rd_addr;
  logic        prev_strobe;

  localparam logic [LINE_W-1:0] LINE_24 = 64'h6300_f41c_6100_f01c;
  localparam logic [LINE_W-1:0] LINE_80 = 64'h0004_0003_0002_0001;

  // One clock cycle: log outputs, police strobes, play the memory, advance.
  task automatic tick();
    logic st;
    st = bus.mem_read | bus.mem_write;
    if (st === 1'b1) obs_s.push_back(strobe_t'{cyc, bus.mem_write, bus.mem_addr, bus.mem_wdata});
    if (bus.i_done === 1'b1) obs_d.push_back(done_t'{cyc, 1'b0, bus.i_rline, bus.d_rline});
    if (bus.d_done === 1'b1) obs_d.push_back(done_t'{cyc, 1'b1, bus.i_rline, bus.d_rline});
    checks++;
    if ((bus.mem_read & bus.mem_write) === 1'b1) begin
      errors++;
      $display("FAIL strobe_both cyc=%0d read=%b write=%b required not both", cyc, bus.mem_read, bus.mem_write);
    end
    checks++;
    if (st === 1'b1 && prev_strobe === 1'b1) begin
      errors++;
      $display("FAIL strobe_adjacent cyc=%0d strobe=%b prev=%b required no back-to-back", cyc, st, prev_strobe);
    end
    prev_strobe = st;
    if (bus.mem_write === 1'b1) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
    if (bus.mem_read === 1'b1) begin
      rd_cyc  = cyc + MEM_LAT;
      rd_addr = bus.mem_addr[7:0];
    end
    bus.mem_rdata = (cyc == rd_cyc) ? mem[rd_addr] : 16'hxxxx;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Tick until n done pulses are logged or the budget runs out; each
  // requester drops its req in the cycle after its done.
  task automatic run_until(input int n, input int budget);
    for (int k = 0; k < budget && obs_d.size() < n; k++) begin
      tick();
      if (obs_d.size() > 0 && obs_d[$].cyc == cyc - 1) begin
        if (obs_d[$].d) bus.d_req = 1'b0;
        else            bus.i_req = 1'b0;
      end
    end
  endtask

  task automatic clear_logs();
    obs_s.delete();
    obs_d.delete();
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.i_addr  = '0;
    bus.d_addr  = '0;
    bus.d_wline = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.i_done, bus.d_done} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=0000", {bus.mem_read, bus.mem_write, bus.i_done, bus.d_done});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({bus.i_rline, bus.d_rline} !== '0) begin
      errors++;
      $display("FAIL reset_lines i=%h d=%h required 0", bus.i_rline, bus.d_rline);
    end
    clear_logs();
    repeat (3) tick();
    checks++;
    if (obs_s.size() + obs_d.size() != 0) begin
      errors++;
      $display("FAIL reset_idle events=%0d required 0", obs_s.size() + obs_d.size());
    end
  endtask

  task automatic test_i_read();
    int c0;
    clear_logs();
    c0 = cyc;
    bus.i_addr = 16'h0025;
    bus.i_req  = 1'b1;
    run_until(1, 40);
    checks++;
    if (obs_d.size() != 1) begin
      errors++;
      $display("FAIL i_read_done count=%0d required 1", obs_d.size());
    end else begin
      checks++;
      if (obs_d[0].d !== 1'b0 || obs_d[0].cyc - c0 != XFER) begin
        errors++;
        $display("FAIL i_read_latency side=%b lat=%0d required I %0d", obs_d[0].d, obs_d[0].cyc - c0, XFER);
      end
      checks++;
      if (obs_d[0].il !== LINE_24) begin
        errors++;
        $display("FAIL i_read_line got=%h required=%h", obs_d[0].il, LINE_24);
      end
    end
    checks++;
    if (obs_s.size() != LINE_WORDS) begin
      errors++;
      $display("FAIL i_read_strobes count=%0d required %0d", obs_s.size(), LINE_WORDS);
    end else begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        checks++;
        if (obs_s[k].we !== 1'b0 || obs_s[k].addr !== 16'(16'h0024 + k) || obs_s[k].cyc != c0 + 1 + k * STEP) begin
          errors++;
          $display("FAIL i_read_word%0d we=%b addr=%h cyc=%0d required read %h cyc %0d",
                   k, obs_s[k].we, obs_s[k].addr, obs_s[k].cyc, 16'h0024 + k, c0 + 1 + k * STEP);
        end
      end
    end
  endtask

  task automatic test_d_write();
    int c0;
    clear_logs();
    c0 = cyc;
    bus.d_addr  = 16'h0082;
    bus.d_we    = 1'b1;
    bus.d_wline = LINE_80;
    bus.d_req   = 1'b1;
    run_until(1, 40);
    checks++;
    if (obs_d.size() != 1 || obs_d[0].d !== 1'b1 || obs_d[0].cyc - c0 != XFER) begin
      errors++;
      $display("FAIL d_write_done count=%0d required 1 D done at +%0d", obs_d.size(), XFER);
    end
    checks++;
    if (obs_s.size() != LINE_WORDS) begin
      errors++;
      $display("FAIL d_write_strobes count=%0d required %0d", obs_s.size(), LINE_WORDS);
    end else begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        checks++;
        if (obs_s[k].we !== 1'b1 || obs_s[k].addr !== 16'(16'h0080 + k) || obs_s[k].data !== 16'(k + 1)) begin
          errors++;
          $display("FAIL d_write_word%0d we=%b addr=%h data=%h required write %h data %h",
                   k, obs_s[k].we, obs_s[k].addr, obs_s[k].data, 16'h0080 + k, k + 1);
        end
      end
    end
    tick();
    clear_logs();
    c0 = cyc;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0080;
    bus.d_req  = 1'b1;
    run_until(1, 40);
    checks++;
    if (obs_d.size() != 1) begin
      errors++;
      $display("FAIL d_read_done count=%0d required 1", obs_d.size());
    end else begin
      checks++;
      if (obs_d[0].dl !== LINE_80 || obs_d[0].cyc - c0 != XFER) begin
        errors++;
        $display("FAIL d_read_line got=%h lat=%0d required=%h lat %0d", obs_d[0].dl, obs_d[0].cyc - c0, LINE_80, XFER);
      end
    end
  endtask

  task automatic test_hold();
    int c0;
    tick();
    clear_logs();
    c0 = cyc;
    bus.i_addr = 16'h0024;
    bus.i_req  = 1'b1;
    repeat (3) tick();
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0080;
    bus.d_req  = 1'b1;
    run_until(2, 60);
    checks++;
    if (obs_d.size() != 2) begin
      errors++;
      $display("FAIL hold_done count=%0d required 2", obs_d.size());
    end else begin
      checks++;
      if (obs_d[0].d !== 1'b0 || obs_d[0].cyc != c0 + XFER || obs_d[0].il !== LINE_24) begin
        errors++;
        $display("FAIL hold_i side=%b cyc=%0d line=%h required I cyc %0d line %h",
                 obs_d[0].d, obs_d[0].cyc, obs_d[0].il, c0 + XFER, LINE_24);
      end
      checks++;
      if (obs_d[1].d !== 1'b1 || obs_d[1].cyc != c0 + 2 * XFER + 1 || obs_d[1].dl !== LINE_80 || obs_d[1].il !== LINE_24) begin
        errors++;
        $display("FAIL hold_d side=%b cyc=%0d dl=%h il=%h required D cyc %0d dl %h il %h",
                 obs_d[1].d, obs_d[1].cyc, obs_d[1].dl, obs_d[1].il, c0 + 2 * XFER + 1, LINE_80, LINE_24);
      end
    end
    checks++;
    if (obs_s.size() != 2 * LINE_WORDS) begin
      errors++;
      $display("FAIL hold_strobes count=%0d required %0d", obs_s.size(), 2 * LINE_WORDS);
    end else begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        checks++;
        if (obs_s[k].addr !== 16'(16'h0024 + k) || obs_s[k + LINE_WORDS].addr !== 16'(16'h0080 + k)
            || obs_s[k + LINE_WORDS].cyc != c0 + XFER + 2 + k * STEP) begin
          errors++;
          $display("FAIL hold_order%0d i_addr=%h d_addr=%h d_cyc=%0d required %h %h %0d", k, obs_s[k].addr,
                   obs_s[k + LINE_WORDS].addr, obs_s[k + LINE_WORDS].cyc, 16'h0024 + k, 16'h0080 + k, c0 + XFER + 2 + k * STEP);
        end
      end
    end
  endtask

  task automatic test_back_to_back_tie();
    int c0;
    do_reset();
    clear_logs();
    c0 = cyc;
    bus.i_addr = 16'h0024;
    bus.d_addr = 16'h0080;
    bus.d_we   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    run_until(2, 70);
    checks++;
    if (obs_d.size() != 2) begin
      errors++;
      $display("FAIL tie1_done count=%0d required 2", obs_d.size());
    end else begin
      checks++;
      if (obs_d[0].d !== 1'b1 || obs_d[0].cyc != c0 + XFER || obs_d[0].dl !== LINE_80) begin
        errors++;
        $display("FAIL tie1_first side=%b cyc=%0d dl=%h required D cyc %0d dl %h", obs_d[0].d, obs_d[0].cyc, obs_d[0].dl, c0 + XFER, LINE_80);
      end
      checks++;
      if (obs_d[1].d !== 1'b0 || obs_d[1].cyc != c0 + 2 * XFER + 1 || obs_d[1].il !== LINE_24) begin
        errors++;
        $display("FAIL tie1_second side=%b cyc=%0d il=%h required I cyc %0d il %h", obs_d[1].d, obs_d[1].cyc, obs_d[1].il, c0 + 2 * XFER + 1, LINE_24);
      end
    end
    checks++;
    if (obs_s.size() != 2 * LINE_WORDS || obs_s[LINE_WORDS].cyc != c0 + XFER + 2 || obs_s[LINE_WORDS].addr !== 16'h0024) begin
      errors++;
      $display("FAIL tie1_i_first_strobe count=%0d required I word0 at cyc %0d", obs_s.size(), c0 + XFER + 2);
    end
    // D-only line leaves last_grant = D, so the next tie goes to I.
    tick();
    clear_logs();
    bus.d_addr = 16'h0026;
    bus.d_req  = 1'b1;
    run_until(1, 40);
    checks++;
    if (obs_d.size() != 1 || obs_d[0].d !== 1'b1 || obs_d[0].dl !== LINE_24 || obs_d[0].il !== LINE_24) begin
      errors++;
      $display("FAIL d_only count=%0d required D line %h", obs_d.size(), LINE_24);
    end
    tick();
    clear_logs();
    c0 = cyc;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    run_until(2, 70);
    checks++;
    if (obs_d.size() != 2 || obs_d[0].d !== 1'b0 || obs_d[0].cyc != c0 + XFER
        || obs_d[1].d !== 1'b1 || obs_d[1].cyc != c0 + 2 * XFER + 1) begin
      errors++;
      $display("FAIL tie2_order count=%0d required I at %0d then D at %0d", obs_d.size(), c0 + XFER, c0 + 2 * XFER + 1);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    tick();
    clear_logs();
    c0 = cyc;
    bus.i_addr = 16'h0024;
    bus.i_req  = 1'b1;
    while (cyc < c0 + 1 + 2 * STEP + 1) tick();
    reset_n   = 1'b0;
    bus.i_req = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.i_done} !== 3'b0 || bus.i_rline !== '0) begin
      errors++;
      $display("FAIL reset_mid_now rd=%b wr=%b done=%b line=%h required all 0", bus.mem_read, bus.mem_write, bus.i_done, bus.i_rline);
    end
    repeat (6) tick();
    checks++;
    if (obs_d.size() != 0 || obs_s.size() != 3) begin
      errors++;
      $display("FAIL reset_mid_abort dones=%0d strobes=%0d required 0 and 3", obs_d.size(), obs_s.size());
    end
    clear_logs();
    c0 = cyc;
    bus.i_addr = 16'h0025;
    bus.i_req  = 1'b1;
    run_until(1, 40);
    checks++;
    if (obs_d.size() != 1 || obs_d[0].cyc != c0 + XFER || obs_d[0].il !== LINE_24 || obs_s.size() != LINE_WORDS) begin
      errors++;
      $display("FAIL reset_mid_refill dones=%0d strobes=%0d required 1 done at +%0d line %h", obs_d.size(), obs_s.size(), XFER, LINE_24);
    end
  endtask

  task automatic test_random();
    logic                 last_d;
    logic [LINE_W-1:0]    exp_il, exp_dl, dwl, line;
    logic [15:0]          ia, da, a, base;
    logic                 dwe, side, we;
    logic [7:0]           ma;
    logic                 sides [2];
    int                   mode, n, c0, ts;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    last_d = 1'b0;
    exp_il = '0;
    exp_dl = '0;
    for (int r = 0; r < 25; r++) begin
      mode = $urandom_range(0, 2);
      ia   = 16'($urandom);
      da   = 16'($urandom);
      dwe  = 1'($urandom_range(0, 1));
      dwl  = {$urandom, $urandom};
      if (mode == 2) begin
        n        = 2;
        sides[0] = ~last_d;
        sides[1] = last_d;
      end else begin
        n        = 1;
        sides[0] = (mode == 1);
        sides[1] = 1'b0;
      end
      clear_logs();
      c0 = cyc;
      bus.i_addr  = ia;
      bus.d_addr  = da;
      bus.d_we    = dwe;
      bus.d_wline = dwl;
      bus.i_req   = (mode != 1);
      bus.d_req   = (mode != 0);
      run_until(n, 70);
      checks++;
      if (obs_d.size() != n || obs_s.size() != n * LINE_WORDS) begin
        errors++;
        $display("FAIL rand%0d_counts dones=%0d strobes=%0d required %0d %0d", r, obs_d.size(), obs_s.size(), n, n * LINE_WORDS);
      end else begin
        for (int s = 0; s < n; s++) begin
          side = sides[s];
          ts   = c0 + s * (XFER + 1);
          a    = side ? da : ia;
          we   = side & dwe;
          base = a & ~16'(LINE_WORDS - 1);
          line = '0;
          for (int k = 0; k < LINE_WORDS; k++) begin
            ma = 8'(base + 16'(k));
            if (we) ref_mem[ma] = dwl[k*16 +: 16];
            line[k*16 +: 16] = ref_mem[ma];
            checks++;
            if (obs_s[s*LINE_WORDS + k].cyc != ts + 1 + k * STEP || obs_s[s*LINE_WORDS + k].we !== we
                || obs_s[s*LINE_WORDS + k].addr !== 16'(base + 16'(k))
                || (we && obs_s[s*LINE_WORDS + k].data !== dwl[k*16 +: 16])) begin
              errors++;
              $display("FAIL rand%0d_strobe%0d_%0d cyc=%0d we=%b addr=%h data=%h required cyc %0d we %b addr %h data %h",
                       r, s, k, obs_s[s*LINE_WORDS + k].cyc, obs_s[s*LINE_WORDS + k].we, obs_s[s*LINE_WORDS + k].addr,
                       obs_s[s*LINE_WORDS + k].data, ts + 1 + k * STEP, we, base + 16'(k), dwl[k*16 +: 16]);
            end
          end
          if (!we) begin
            if (side) exp_dl = line;
            else      exp_il = line;
          end
          checks++;
          if (obs_d[s].cyc != ts + XFER || obs_d[s].d !== side || obs_d[s].il !== exp_il || obs_d[s].dl !== exp_dl) begin
            errors++;
            $display("FAIL rand%0d_done%0d cyc=%0d side=%b il=%h dl=%h required cyc %0d side %b il %h dl %h",
                     r, s, obs_d[s].cyc, obs_d[s].d, obs_d[s].il, obs_d[s].dl, ts + XFER, side, exp_il, exp_dl);
          end
          last_d = side;
        end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    cyc         = 0;
    checks      = 0;
    errors      = 0;
    rd_cyc      = -1;
    rd_addr     = '0;
    prev_strobe = 1'b0;
    reset_n     = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h24] = 16'hf01c;
    mem[8'h25] = 16'h6100;
    mem[8'h26] = 16'hf41c;
    mem[8'h27] = 16'h6300;
    test_reset();
    test_i_read();
    test_d_write();
    test_hold();
    test_back_to_back_tie();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
